npc_trap_csr: RTL and testbench
===============================

Name: npc_trap_csr

Overview:
- Machine-mode trap responder for the NPC core: the receiving end of the ecall/mret detection done at decode.
- Holds the trap CSRs mstatus, mtvec, mepc and mcause, and services CSR read/modify instructions.
- On ecall it saves state and redirects the fetch unit to mtvec; on mret it restores state and redirects to mepc.
- Redirects to the IFU use a valid/ready handshake; the core stalls while the block is busy.

Parameters:
- XLEN, 32, data and PC width.
- ECALL_CAUSE, 32'd11, value written to mcause on ecall (environment call from M-mode).
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=2'b11).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- inst_valid  input  1  inst/pc hold a retiring instruction this cycle
- inst  input  32  instruction word
- pc  input  XLEN  PC of inst
- csr_we  input  1  CSR instruction writes this cycle
- csr_op  input  2  00 write, 01 set bits, 10 clear bits, 11 reserved (no write)
- csr_addr  input  12  CSR address
- csr_wdata  input  XLEN  rs1/zimm operand
- csr_rdata  output  XLEN  combinational old value of csr_addr
- busy  output  1  state != IDLE; the core must hold the PC and retire nothing
- redirect_valid  output  1  redirect_pc is valid
- redirect_pc  output  XLEN  fetch target
- redirect_ready  input  1  IFU accepts the redirect
- trap_count  output  32  number of ecalls taken since reset

Behaviour:
- Reset (async, any state): state=IDLE; mstatus=MSTATUS_RST; mtvec, mepc, mcause, trap_count all 0. Outputs: redirect_valid=0, redirect_pc=0, busy=0.
- Decode: ecall iff inst==32'h0000_0073; mret iff inst==32'h3020_0073. Each is qualified by inst_valid and state==IDLE.
- CSR map:
  - 0x300 mstatus (MIE bit3, MPIE bit7, MPP bits12:11 hardwired 2'b11).
  - 0x305 mtvec (bits1:0 read 0, direct mode only).
  - 0x341 mepc (bits1:0 read 0).
  - 0x342 mcause (full 32 bits).
  - Unmapped addresses read 0; writes to them are ignored.
- CSR write: new = wdata / old|wdata / old&~wdata per csr_op. Applied at the clock edge only when csr_we=1, state==IDLE, and neither ecall nor mret is decoded.
- csr_rdata: pure combinational old value, valid in any state.
- FSM states: IDLE, REDIRECT.
- IDLE + ecall, at the edge:
  - mepc<=pc; mcause<=ECALL_CAUSE.
  - MPIE<=MIE; MIE<=0.
  - target<=mtvec value before this edge.
  - trap_count+=1 (wraps at 2^32).
  - state->REDIRECT.
- IDLE + mret, at the edge:
  - MIE<=MPIE; MPIE<=1.
  - target<=mepc value before this edge.
  - state->REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target; both held stable until redirect_ready=1.
  - On the edge with redirect_ready=1: state->IDLE and redirect_valid drops next cycle.
- Latency: ecall/mret accepted in cycle N → redirect_valid=1 in N+1. With ready high, a back-to-back new trap can be accepted in cycle N+2.
- redirect_pc retains the last target after handshake; only redirect_valid qualifies it.
- Ignored while busy: inst_valid, csr_we, ecall and mret are all ignored. No CSR changes while in REDIRECT.
- Priority: ecall/mret beats a simultaneous csr_we, which is dropped. ecall and mret are mutually exclusive by encoding.
- Reset during REDIRECT: redirect_valid drops immediately (async), all CSRs return to reset values, and the pending redirect is lost.
- mret with mepc=0 is legal and redirects to 0.
- trap_count does not increment on mret.

Test Plan:
- Reset → all outputs 0, csr_rdata@0x300 = 32'h1800, @0x305/0x341/0x342 = 0.
- csr_we, op=00, addr 0x305, wdata 32'h8000_0103 → read 32'h8000_0100. Then op=01, addr 0x300, wdata 8 → mstatus 32'h1808.
- Ecall (MIE=1, pc=32'h8000_0040, ready=1):
  - Next cycle: redirect_valid=1, redirect_pc=32'h8000_0100, busy=1.
  - Then: mepc=32'h8000_0040, mcause=11, mstatus=32'h1880, trap_count=1.
  - Following cycle: busy=0.
- Ecall with redirect_ready held 0 for 3 cycles:
  - redirect_valid and redirect_pc stay stable for 4 cycles.
  - A csr_we to mtvec issued meanwhile leaves mtvec unchanged.
- Ecall then mret:
  - mret redirects to 32'h8000_0040 one cycle later; mstatus returns to 32'h1888; trap_count stays 1.
  - ecall and csr_we in the same cycle: CSR write is dropped.
- Assert rst mid-REDIRECT → redirect_valid falls without a clock edge, mepc=0, state IDLE; the next ecall after release works normally.

Source files
------------

// File: rtl/npc_trap_csr.sv
// npc_trap_csr: machine-mode trap CSRs and the ecall/mret redirect.
// Holds mstatus/mtvec/mepc/mcause and steers fetch on trap entry and exit.
module npc_trap_csr #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            csr_we,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [31:0]     trap_count
);

  localparam logic [31:0] ECALL_INST = 32'h0000_0073;
  localparam logic [31:0] MRET_INST  = 32'h3020_0073;

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_e;

  state_e state_q, state_d;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:2] mtvec_q, mtvec_d;
  logic [XLEN-1:2] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            is_idle;
  logic            ecall;
  logic            mret;
  logic            csr_wr;
  logic            hit_mstatus;
  logic            hit_mtvec;
  logic            hit_mepc;
  logic            hit_mcause;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] csr_new;
  logic            unused;

  assign unused = ^pc[1:0];

  assign is_idle = (state_q == IDLE);
  assign ecall   = inst_valid & is_idle & (inst == ECALL_INST);
  assign mret    = inst_valid & is_idle & (inst == MRET_INST);
  assign csr_wr  = csr_we & is_idle & ~ecall & ~mret
                 & (csr_op != 2'b11);

  assign hit_mstatus = (csr_addr == 12'h300);
  assign hit_mtvec   = (csr_addr == 12'h305);
  assign hit_mepc    = (csr_addr == 12'h341);
  assign hit_mcause  = (csr_addr == 12'h342);

  // MPP is hardwired to M-mode; only MIE and MPIE hold state
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie_q;
    mstatus_val[3]     = mie_q;
  end

  always_comb begin
    csr_rdata = '0;
    unique case (1'b1)
      hit_mstatus: csr_rdata = mstatus_val;
      hit_mtvec:   csr_rdata = {mtvec_q, 2'b00};
      hit_mepc:    csr_rdata = {mepc_q, 2'b00};
      hit_mcause:  csr_rdata = mcause_q;
      default:     csr_rdata = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_rdata;
    unique case (csr_op)
      2'b00:   csr_new = csr_wdata;
      2'b01:   csr_new = csr_rdata | csr_wdata;
      2'b10:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      ecall: begin
        mepc_d   = pc[XLEN-1:2];
        mcause_d = XLEN'(ECALL_CAUSE);
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        target_d = {mtvec_q, 2'b00};
        cnt_d    = cnt_q + 32'd1;
      end
      mret: begin
        mie_d    = mpie_q;
        mpie_d   = 1'b1;
        target_d = {mepc_q, 2'b00};
      end
      csr_wr: begin
        if (hit_mstatus) begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        if (hit_mtvec)  mtvec_d  = csr_new[XLEN-1:2];
        if (hit_mepc)   mepc_d   = csr_new[XLEN-1:2];
        if (hit_mcause) mcause_d = csr_new;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ecall | mret)  state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = (state_q == REDIRECT);
    busy           = (state_q == REDIRECT);
    redirect_pc    = target_q;
    trap_count     = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mie_q    <= MSTATUS_RST[3];
      mpie_q   <= MSTATUS_RST[7];
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_trap_csr.sv
// tb_npc_trap_csr: vector table, directed trap sequences and random
// stimulus checked against a behavioural model of the trap CSRs.
module tb_npc_trap_csr;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [31:0] trap_count;

  int checks;
  int errors;

  bit          m_mie, m_mpie, m_busy;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_target, m_cnt;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  npc_trap_csr dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc             (pc),
    .csr_we         (csr_we),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .trap_count     (trap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_busy = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    m_target = 0; m_cnt = 0;
  endtask

  task automatic m_write(input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd);
    logic [31:0] old, nv;
    old = m_read(a);
    case (op)
      2'd0: nv = wd;
      2'd1: nv = old | wd;
      2'd2: nv = old & ~wd;
      default: return;
    endcase
    case (a)
      12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
      12'h305: m_mtvec  = nv & ~32'd3;
      12'h341: m_mepc   = nv & ~32'd3;
      12'h342: m_mcause = nv;
      default: ;
    endcase
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (!m_busy) begin
      if (inst_valid && inst == ECALL) begin
        m_target = m_mtvec;
        m_mepc   = pc & ~32'd3;
        m_mcause = 32'd11;
        m_mpie   = m_mie;
        m_mie    = 0;
        m_cnt    = m_cnt + 1;
        m_busy   = 1;
      end else if (inst_valid && inst == MRET) begin
        m_target = m_mepc;
        m_mie    = m_mpie;
        m_mpie   = 1;
        m_busy   = 1;
      end else if (csr_we) begin
        m_write(csr_addr, csr_op, csr_wdata);
      end
    end else if (redirect_ready) m_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                    input string nm);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  task automatic check_all();
    chk("rnd_rdata", csr_rdata, m_read(csr_addr));
    chk("rnd_busy", 32'(busy), 32'(m_busy));
    chk("rnd_valid", 32'(redirect_valid), 32'(m_busy));
    chk("rnd_rpc", redirect_pc, m_target);
    chk("rnd_cnt", trap_count, m_cnt);
  endtask

  task automatic idle_in();
    inst_valid = 0;
    inst       = 0;
    csr_we     = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = '{2'd0, 12'h305, 32'h8000_0103, 32'h8000_0100};
    tbl[1]  = '{2'd1, 12'h300, 32'h0000_0008, 32'h0000_1808};
    tbl[2]  = '{2'd2, 12'h300, 32'h0000_0008, 32'h0000_1800};
    tbl[3]  = '{2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    tbl[4]  = '{2'd2, 12'h300, 32'h0000_0080, 32'h0000_1808};
    tbl[5]  = '{2'd0, 12'h341, 32'h1234_5677, 32'h1234_5674};
    tbl[6]  = '{2'd0, 12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[7]  = '{2'd3, 12'h342, 32'h0000_0000, 32'hDEAD_BEEF};
    tbl[8]  = '{2'd0, 12'h123, 32'h0000_FFFF, 32'h0000_0000};
    tbl[9]  = '{2'd2, 12'h342, 32'h0000_FFFF, 32'hDEAD_0000};
    tbl[10] = '{2'd0, 12'h305, 32'h8000_0103, 32'h8000_0100};

    rst = 1;
    idle_in();
    pc = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    redirect_ready = 1;
    model_reset();
    #1;
    chk("rst_valid", 32'(redirect_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_cnt", trap_count, 32'h0);
    rd(12'h300, 32'h1800, "rst_mstatus");
    rd(12'h305, 32'h0, "rst_mtvec");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      csr_we = 1;
      csr_op = tbl[i].op;
      csr_addr = tbl[i].addr;
      csr_wdata = tbl[i].wdata;
      tick();
      csr_we = 0;
      rd(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // ecall with ready high
    inst_valid = 1; inst = ECALL; pc = 32'h8000_0040;
    tick();
    idle_in();
    chk("ec_valid", 32'(redirect_valid), 32'h1);
    chk("ec_rpc", redirect_pc, 32'h8000_0100);
    chk("ec_busy", 32'(busy), 32'h1);
    chk("ec_cnt", trap_count, 32'h1);
    rd(12'h341, 32'h8000_0040, "ec_mepc");
    rd(12'h342, 32'd11, "ec_mcause");
    rd(12'h300, 32'h1880, "ec_mstatus");
    tick();
    chk("ec_idle", 32'(busy), 32'h0);
    chk("ec_rpc_kept", redirect_pc, 32'h8000_0100);

    // ecall with ready held low; csr write meanwhile is ignored
    redirect_ready = 0;
    inst_valid = 1; inst = ECALL; pc = 32'h8000_0080;
    tick();
    idle_in();
    csr_we = 1; csr_op = 0; csr_addr = 12'h305; csr_wdata = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", 32'(redirect_valid), 32'h1);
      chk("hold_rpc", redirect_pc, 32'h8000_0100);
      tick();
    end
    redirect_ready = 1;
    #1;
    chk("hold_valid4", 32'(redirect_valid), 32'h1);
    chk("hold_rpc4", redirect_pc, 32'h8000_0100);
    tick();
    csr_we = 0;
    chk("hold_idle", 32'(busy), 32'h0);
    rd(12'h305, 32'h8000_0100, "hold_mtvec");
    rd(12'h300, 32'h1800, "hold_mstatus");
    rd(12'h341, 32'h8000_0080, "hold_mepc");

    // ecall + simultaneous csr write, then mret
    csr_we = 1; csr_op = 1; csr_addr = 12'h300; csr_wdata = 8;
    tick();
    csr_we = 0;
    rd(12'h300, 32'h1808, "set_mie");
    inst_valid = 1; inst = ECALL; pc = 32'h8000_0040;
    csr_we = 1; csr_op = 0; csr_addr = 12'h305; csr_wdata = 0;
    tick();
    idle_in();
    chk("pri_rpc", redirect_pc, 32'h8000_0100);
    rd(12'h305, 32'h8000_0100, "pri_drop");
    rd(12'h300, 32'h1880, "pri_mstatus");
    chk("pri_cnt", trap_count, 32'd3);
    tick();
    inst_valid = 1; inst = MRET;
    tick();
    idle_in();
    chk("mret_valid", 32'(redirect_valid), 32'h1);
    chk("mret_rpc", redirect_pc, 32'h8000_0040);
    rd(12'h300, 32'h1888, "mret_mstatus");
    chk("mret_cnt", trap_count, 32'd3);
    tick();
    chk("mret_idle", 32'(busy), 32'h0);

    // async reset in the middle of a redirect
    redirect_ready = 0;
    inst_valid = 1; inst = ECALL; pc = 32'h8000_00C0;
    tick();
    idle_in();
    chk("ar_valid", 32'(redirect_valid), 32'h1);
    rst = 1;
    model_reset();
    #1;
    chk("ar_drop", 32'(redirect_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_cnt", trap_count, 32'h0);
    rd(12'h341, 32'h0, "ar_mepc");
    rd(12'h300, 32'h1800, "ar_mstatus");
    @(negedge clk);
    rst = 0;
    redirect_ready = 1;
    inst_valid = 1; inst = MRET;
    tick();
    idle_in();
    chk("m0_valid", 32'(redirect_valid), 32'h1);
    chk("m0_rpc", redirect_pc, 32'h0);
    chk("m0_cnt", trap_count, 32'h0);
    tick();
    inst_valid = 1; inst = ECALL; pc = 32'h8000_0200;
    tick();
    idle_in();
    chk("ar2_valid", 32'(redirect_valid), 32'h1);
    chk("ar2_rpc", redirect_pc, 32'h0);
    chk("ar2_cnt", trap_count, 32'h1);
    rd(12'h341, 32'h8000_0200, "ar2_mepc");
    tick();

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [11:0] addrs[5];
      addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 0;
        continue;
      end
      inst_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: inst = ECALL;
        1: inst = MRET;
        default: inst = $urandom;
      endcase
      pc = $urandom;
      csr_we = 1'($urandom_range(0, 1));
      csr_op = 2'($urandom_range(0, 3));
      csr_addr = addrs[$urandom_range(0, 4)];
      csr_wdata = $urandom;
      redirect_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
